// File: rtl/idex_if.sv
// idex_if: ID/EX stage handshake and payload bundle; slave = the stage, master = its environment
interface idex_if #(parameter int XLEN = 32, parameter int CTRLW = 16);
  logic             in_valid, in_ready;
  logic [XLEN-1:0]  ifid_pc, ifid_imm;
  logic [4:0]       ifid_rs1, ifid_rs2, ifid_rd;
  logic             ifid_rs1able, ifid_rs2able, ifid_wreg, ifid_memread, ifid_memwrite;
  logic [CTRLW-1:0] ifid_ctrl;
  logic [XLEN-1:0]  rf_rdata1, rf_rdata2, lswb_wdata;
  logic             ca3, cb3, flush;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  idex_pc, idex_imm, idex_src1, idex_src2;
  logic [4:0]       idex_rs1, idex_rs2, idex_rd;
  logic             idex_rs1able, idex_rs2able, idex_wreg, idex_memread, idex_memwrite;
  logic [CTRLW-1:0] idex_ctrl;
  logic             loadused;
  modport slave (
    input  in_valid, ifid_pc, ifid_imm, ifid_rs1, ifid_rs2, ifid_rd, ifid_rs1able, ifid_rs2able,
           ifid_wreg, ifid_memread, ifid_memwrite, ifid_ctrl, rf_rdata1, rf_rdata2, lswb_wdata,
           ca3, cb3, flush, out_ready,
    output in_ready, out_valid, idex_pc, idex_imm, idex_src1, idex_src2, idex_rs1, idex_rs2, idex_rd,
           idex_rs1able, idex_rs2able, idex_wreg, idex_memread, idex_memwrite, idex_ctrl, loadused
  );
  modport master (
    output in_valid, ifid_pc, ifid_imm, ifid_rs1, ifid_rs2, ifid_rd, ifid_rs1able, ifid_rs2able,
           ifid_wreg, ifid_memread, ifid_memwrite, ifid_ctrl, rf_rdata1, rf_rdata2, lswb_wdata,
           ca3, cb3, flush, out_ready,
    input  in_ready, out_valid, idex_pc, idex_imm, idex_src1, idex_src2, idex_rs1, idex_rs2, idex_rd,
           idex_rs1able, idex_rs2able, idex_wreg, idex_memread, idex_memwrite, idex_ctrl, loadused
  );
endinterface

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with WB operand capture and load-use interlock
// IDEX_PERF_EN adds perf_bubble_cnt / perf_stall_cnt counters
module idex_stage #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 16
) (
  input  logic        clk,
  input  logic        rst,
  idex_if.slave       bus
`ifdef IDEX_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  typedef struct packed {
    logic [XLEN-1:0]  pc, imm, src1, src2;
    logic [4:0]       rs1, rs2, rd;
    logic             rs1able, rs2able, wreg, memread, memwrite;
    logic [CTRLW-1:0] ctrl;
  } pl_t;
  pl_t  pl_q, pl_d;
  logic v_q, v_d, lu, load;
  always_comb begin
    lu = v_q & pl_q.memread & pl_q.wreg & (|pl_q.rd) & bus.in_valid &
         ((pl_q.rd == bus.ifid_rs1 & bus.ifid_rs1able) | (pl_q.rd == bus.ifid_rs2 & bus.ifid_rs2able));
    bus.in_ready = bus.flush | ((~v_q | bus.out_ready) & ~lu);
    load = bus.in_valid & bus.in_ready & ~bus.flush;
    // bubble and drain both clear v when EX takes the entry and nothing new loads
    v_d = bus.flush ? 1'b0 : load ? 1'b1 : v_q & ~bus.out_ready;
    pl_d = load ? pl_t'{pc: bus.ifid_pc, imm: bus.ifid_imm,
                        src1: bus.ca3 ? bus.lswb_wdata : bus.rf_rdata1,
                        src2: bus.cb3 ? bus.lswb_wdata : bus.rf_rdata2,
                        rs1: bus.ifid_rs1, rs2: bus.ifid_rs2, rd: bus.ifid_rd,
                        rs1able: bus.ifid_rs1able, rs2able: bus.ifid_rs2able, wreg: bus.ifid_wreg,
                        memread: bus.ifid_memread, memwrite: bus.ifid_memwrite, ctrl: bus.ifid_ctrl}
                : pl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= 1'b0;
      pl_q <= '0;
    end else begin
      v_q  <= v_d;
      pl_q <= pl_d;
    end
  end
  assign bus.loadused      = lu;
  assign bus.out_valid     = v_q;
  assign bus.idex_pc       = pl_q.pc;
  assign bus.idex_imm      = pl_q.imm;
  assign bus.idex_src1     = pl_q.src1;
  assign bus.idex_src2     = pl_q.src2;
  assign bus.idex_rs1      = pl_q.rs1;
  assign bus.idex_rs2      = pl_q.rs2;
  assign bus.idex_rd       = pl_q.rd;
  assign bus.idex_ctrl     = pl_q.ctrl;
  // gated so a held bubble never forwards or writes
  assign bus.idex_rs1able  = pl_q.rs1able & v_q;
  assign bus.idex_rs2able  = pl_q.rs2able & v_q;
  assign bus.idex_wreg     = pl_q.wreg & v_q;
  assign bus.idex_memread  = pl_q.memread & v_q;
  assign bus.idex_memwrite = pl_q.memwrite & v_q;
`ifdef IDEX_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (lu & bus.out_ready & ~bus.flush) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (v_q & ~bus.out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: directed stimulus with scoreboard queue and negedge monitor for idex_stage
module tb_idex_stage;
  localparam logic [4:0] ADDI = 5'b10100, LW = 5'b10110, ADD = 5'b11100, SW = 5'b01001;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  idex_if #(.XLEN(32), .CTRLW(16)) bus ();
`ifdef IDEX_PERF_EN
  logic [31:0] pb, ps;
`endif
  idex_stage #(.XLEN(32), .CTRLW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef IDEX_PERF_EN
    , .perf_bubble_cnt(pb), .perf_stall_cnt(ps)
`endif
  );
  logic [163:0] sb[$];
  int npass = 0, ntot = 0;
  bit started = 0;
  logic [31:0] pc_n = 32'h1000, r1_g = 32'h10, r2_g = 32'h20, a_pc, rv2;
  task automatic chk1(input string nm, input logic a, input logic e);
    ntot++;
    if (a === e) npass++; else $display("FAIL %s: got %b expected %b", nm, a, e);
  endtask
  task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
    ntot++;
    if (a === e) npass++; else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask
  task automatic chkw(input string nm, input logic [163:0] a, input logic [163:0] e);
    ntot++;
    if (a === e) npass++; else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask
  function automatic logic [163:0] actual();
    return {bus.idex_pc, bus.idex_imm, bus.idex_src1, bus.idex_src2, bus.idex_rs1, bus.idex_rs2,
            bus.idex_rd, bus.idex_rs1able, bus.idex_rs2able, bus.idex_wreg, bus.idex_memread,
            bus.idex_memwrite, bus.idex_ctrl};
  endfunction
  always @(negedge clk) begin
    if (started) begin
      if (!bus.out_valid)
        chk1("bubble_flags", |{bus.idex_rs1able, bus.idex_rs2able, bus.idex_wreg, bus.idex_memread, bus.idex_memwrite}, 1'b0);
      else if (bus.out_ready) begin
        if (sb.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_out: got entry pc %h expected none", bus.idex_pc);
        end else chkw("payload", actual(), sb.pop_front());
      end
    end
  end
  task automatic cyc(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic [4:0] fl, input logic ordy, input logic fls,
                     input logic exp_ov, input logic exp_ir, input logic exp_lu);
    logic [15:0] ct;
    ct = pc_n[15:0] ^ 16'hA5A5;
    bus.in_valid = iv;
    bus.ifid_pc = pc_n;
    bus.ifid_imm = ~pc_n;
    bus.ifid_rs1 = rs1;
    bus.ifid_rs2 = rs2;
    bus.ifid_rd = rd;
    {bus.ifid_rs1able, bus.ifid_rs2able, bus.ifid_wreg, bus.ifid_memread, bus.ifid_memwrite} = fl;
    bus.ifid_ctrl = ct;
    bus.rf_rdata1 = r1_g;
    bus.rf_rdata2 = r2_g;
    bus.out_ready = ordy;
    bus.flush = fls;
    @(negedge clk);
    chk1("out_valid", bus.out_valid, exp_ov);
    chk1("in_ready", bus.in_ready, exp_ir);
    chk1("loadused", bus.loadused, exp_lu);
    if (iv & exp_ir & ~fls)
      sb.push_back({pc_n, ~pc_n, bus.ca3 ? bus.lswb_wdata : r1_g, bus.cb3 ? bus.lswb_wdata : r2_g,
                    rs1, rs2, rd, fl, ct});
    @(posedge clk);
    #1;
    if (iv & exp_ir) pc_n += 4;
    r1_g += 3;
    r2_g += 5;
  endtask
  initial begin
    bus.in_valid = 0; bus.ifid_pc = 0; bus.ifid_imm = 0; bus.ifid_rs1 = 0; bus.ifid_rs2 = 0;
    bus.ifid_rd = 0; bus.ifid_rs1able = 0; bus.ifid_rs2able = 0; bus.ifid_wreg = 0;
    bus.ifid_memread = 0; bus.ifid_memwrite = 0; bus.ifid_ctrl = 0; bus.rf_rdata1 = 0;
    bus.rf_rdata2 = 0; bus.lswb_wdata = 32'hDEADBEEF; bus.ca3 = 0; bus.cb3 = 0; bus.flush = 0;
    bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chkw("reset_payload", actual(), '0);
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk1("reset_in_ready", bus.in_ready, 1'b1);
`ifdef IDEX_PERF_EN
    chk32("reset_bubble_cnt", pb, 32'd0);
    chk32("reset_stall_cnt", ps, 32'd0);
`endif
    @(posedge clk);
    #1 started = 1;
    cyc(1, 0, 0, 1, ADDI, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 2, ADDI, 1, 0, 1, 1, 0);
    cyc(1, 2, 0, 5, LW,   1, 0, 1, 1, 0);
    cyc(1, 5, 7, 6, ADD,  1, 0, 1, 0, 1);
    cyc(1, 5, 7, 6, ADD,  1, 0, 0, 1, 0);
`ifdef IDEX_PERF_EN
    chk32("bubble_cnt_one", pb, 32'd1);
`endif
    cyc(1, 6, 0, 0, LW,   1, 0, 1, 1, 0);
    cyc(1, 0, 0, 8, ADD,  1, 0, 1, 1, 0);
    cyc(1, 0, 0, 5, LW,   1, 0, 1, 1, 0);
    cyc(1, 5, 3, 0, SW,   1, 0, 1, 1, 0);
    bus.ca3 = 1; r1_g = 32'h1; rv2 = r2_g;
    cyc(1, 9, 4, 10, ADDI, 1, 0, 1, 1, 0);
    bus.ca3 = 0;
    chk32("fwd_src1", bus.idex_src1, 32'hDEADBEEF);
    chk32("rf_src2", bus.idex_src2, rv2);
    a_pc = pc_n; bus.cb3 = 1;
    cyc(1, 10, 11, 11, ADD, 1, 0, 1, 1, 0);
    bus.cb3 = 0;
    chk32("fwd_src2", bus.idex_src2, 32'hDEADBEEF);
    cyc(1, 1, 2, 12, ADDI, 0, 0, 1, 0, 0);
    chk32("hold_pc", bus.idex_pc, a_pc);
    cyc(1, 1, 2, 12, ADDI, 0, 1, 1, 1, 0);
    chk32("flush_pc", bus.idex_pc, a_pc);
    sb.delete();
    cyc(0, 0, 0, 0, 5'b0, 0, 0, 0, 1, 0);
    chk32("after_flush_pc", bus.idex_pc, a_pc);
`ifdef IDEX_PERF_EN
    chk32("stall_cnt_two", ps, 32'd2);
`endif
    cyc(1, 0, 0, 5, LW,  1, 0, 0, 1, 0);
    cyc(1, 5, 0, 6, ADD, 1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 5'b0, 1, 0, 0, 1, 0);
`ifdef IDEX_PERF_EN
    chk32("flush_no_bubble", pb, 32'd1);
`endif
    cyc(1, 0, 0, 5, LW,  0, 0, 0, 1, 0);
    rst = 1;
    cyc(1, 5, 0, 6, ADD, 0, 0, 1, 0, 1);
    rst = 0;
    sb.delete();
    cyc(0, 0, 0, 0, 5'b0, 0, 0, 0, 1, 0);
`ifdef IDEX_PERF_EN
    chk32("rst_bubble_cnt", pb, 32'd0);
    chk32("rst_stall_cnt", ps, 32'd0);
`endif
    chk1("sb_empty", sb.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
